// File: rtl/memory_bus_pkg.sv
// Shared types and helpers for memory_bus_router: FSM state encoding,
// default bank geometry and bank-index extraction from a CPU address.
package memory_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_BANK_BITS  = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int NUM_BANKS      = 1 << DEF_BANK_BITS;
  localparam int MASK_WIDTH     = DEF_DATA_WIDTH / 8;

  // Bank index = top bank_bits of an addr_width-bit byte address.
  function automatic int unsigned bank_index(input logic [63:0] addr,
                                             input int unsigned addr_width,
                                             input int unsigned bank_bits);
    return 32'((addr >> (addr_width - bank_bits)) & ((64'd1 << bank_bits) - 64'd1));
  endfunction

endpackage

// File: rtl/memory_bus_router_watchdog.sv
// bus_watchdog: wait-cycle counter with clear and enable; expired is raised
// on the LIMIT-th consecutive enabled cycle. Used only with MEMORY_BUS_TIMEOUT_EN.
module bus_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CW'(LIMIT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of earlier enabled cycles, so +1 is this cycle.
  assign expired = enable && ((32'(count_q) + 32'd1) >= 32'(LIMIT));

endmodule

// File: rtl/memory_bus_router.sv
// memory_bus_router: routes one CPU access to one of 2^BANK_BITS banks with a
// ready handshake, per-bank write protection and optional WAIT timeout
// (enable with macro MEMORY_BUS_TIMEOUT_EN).
module memory_bus_router
  import memory_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BANK_BITS      = 2,
  parameter logic [(2**BANK_BITS)-1:0] WAIT_MASK = 4'b0100,
  parameter logic [(2**BANK_BITS)-1:0] RO_MASK   = 4'b0010,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDR_WIDTH-1:0]                 address,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  input  logic [DATA_WIDTH/8-1:0]               write_mask,
  input  logic                                  write_enable,
  input  logic                                  bus_enable,
  output logic [DATA_WIDTH-1:0]                 data_out,
  output logic                                  bus_ready,
  output logic                                  bus_error,
  output logic [ADDR_WIDTH-BANK_BITS-1:0]       bank_address,
  output logic [DATA_WIDTH-1:0]                 bank_data_in,
  output logic [DATA_WIDTH/8-1:0]               bank_write_mask,
  output logic [(2**BANK_BITS)-1:0]             bank_enable,
  output logic [(2**BANK_BITS)-1:0]             bank_write_enable,
  input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0]  bank_data_out,
  input  logic [(2**BANK_BITS)-1:0]             bank_ready,
  output logic [1:0]                            dbg_state
);

  localparam int NB = 2 ** BANK_BITS;
  localparam int MW = DATA_WIDTH / 8;
  localparam int OW = ADDR_WIDTH - BANK_BITS;

  // Handshake: bus_enable is sampled only in IDLE; every request field is
  // latched there, and bus_ready is a one-cycle strobe with bus_error valid
  // alongside. The CPU drops bus_enable in the bus_ready cycle or a new
  // access starts in the following IDLE cycle.

  state_e                state_q, state_d;
  logic [OW-1:0]         off_q, off_d;
  logic [BANK_BITS-1:0]  bank_q, bank_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MW-1:0]         mask_q, mask_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  sel_slow, sel_ro, sel_ready, timed_out;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [NB-1:0]         sel_onehot;

  assign sel_slow   = WAIT_MASK[bank_q];
  assign sel_ro     = RO_MASK[bank_q];
  assign sel_ready  = bank_ready[bank_q];
  assign sel_rdata  = bank_data_out[32'(bank_q) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_onehot = NB'(1) << bank_q;

`ifdef MEMORY_BUS_TIMEOUT_EN
  bus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_ACCESS),
    .enable  (state_q == ST_WAIT),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    off_d             = off_q;
    bank_d            = bank_q;
    wdata_d           = wdata_q;
    mask_d            = mask_q;
    we_d              = we_q;
    rdata_d           = rdata_q;
    err_d             = err_q;
    bank_enable       = '0;
    bank_write_enable = '0;
    bus_ready         = 1'b0;
    bus_error         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_enable) begin
          off_d   = address[OW-1:0];
          bank_d  = BANK_BITS'(bank_index(64'(address), ADDR_WIDTH, BANK_BITS));
          wdata_d = data_in;
          mask_d  = write_mask;
          we_d    = write_enable;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bank_enable       = sel_onehot;
        bank_write_enable = (we_q && !sel_ro) ? sel_onehot : '0;
        err_d             = we_q && sel_ro;
        if (!sel_slow || sel_ready) begin
          if (!we_q) rdata_d = sel_rdata;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        bank_enable       = sel_onehot;
        bank_write_enable = (we_q && !sel_ro) ? sel_onehot : '0;
        // A late ready on the timeout cycle still wins over the error.
        if (sel_ready) begin
          if (!we_q) rdata_d = sel_rdata;
          state_d = ST_DONE;
        end else if (timed_out) begin
          rdata_d = '1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus_ready = 1'b1;
        bus_error = err_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      bank_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      bank_q  <= bank_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign data_out        = rdata_q;
  assign bank_address    = off_q;
  assign bank_data_in    = wdata_q;
  assign bank_write_mask = mask_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_memory_bus_router.sv
// Directed bench for memory_bus_router: per-cycle strobe/data model driven by
// the transaction task, completion scoreboard and literal latency/data pins.
module tb_memory_bus_router;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BB = 2;
  localparam int NB = 4;
  localparam int MW = 4;
  localparam int TO = 8;
  localparam logic [NB-1:0] SLOW = 4'b0100;
  localparam logic [NB-1:0] RO   = 4'b0010;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     address;
  logic [DW-1:0]     data_in;
  logic [MW-1:0]     write_mask;
  logic              write_enable;
  logic              bus_enable;
  logic [DW-1:0]     data_out;
  logic              bus_ready;
  logic              bus_error;
  logic [AW-BB-1:0]  bank_address;
  logic [DW-1:0]     bank_data_in;
  logic [MW-1:0]     bank_write_mask;
  logic [NB-1:0]     bank_enable;
  logic [NB-1:0]     bank_write_enable;
  logic [NB*DW-1:0]  bank_data_out;
  logic [NB-1:0]     bank_ready;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  memory_bus_router #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BANK_BITS      (BB),
    .WAIT_MASK      (SLOW),
    .RO_MASK        (RO),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .address           (address),
    .data_in           (data_in),
    .write_mask        (write_mask),
    .write_enable      (write_enable),
    .bus_enable        (bus_enable),
    .data_out          (data_out),
    .bus_ready         (bus_ready),
    .bus_error         (bus_error),
    .bank_address      (bank_address),
    .bank_data_in      (bank_data_in),
    .bank_write_mask   (bank_write_mask),
    .bank_enable       (bank_enable),
    .bank_write_enable (bank_write_enable),
    .bank_data_out     (bank_data_out),
    .bank_ready        (bank_ready),
    .dbg_state         (dbg_state)
  );

  logic [DW-1:0] bank_val [NB];
  always_comb bank_data_out = {bank_val[3], bank_val[2], bank_val[1], bank_val[0]};

  // ---------------- model state ----------------
  logic          chk_en = 1'b0;
  logic [NB-1:0] exp_en, exp_we;
  logic          exp_rdy;
  logic [AW-BB-1:0] exp_off;
  logic [DW-1:0] exp_wd;
  logic [MW-1:0] exp_mask;
  logic [DW-1:0] model_data;
  logic [DW:0]   exp_q[$];
  int            ready_cyc = -1;
  logic          last_err = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    if (chk_en) begin
      check("bank_enable", 64'(bank_enable), 64'(exp_en));
      check("bank_write_enable", 64'(bank_write_enable), 64'(exp_we));
      check("bus_ready", 64'(bus_ready), 64'(exp_rdy));
      check("data_out", 64'(data_out), 64'(model_data));
      if (exp_en != '0) begin
        check("bank_address", 64'(bank_address), 64'(exp_off));
        check("bank_data_in", 64'(bank_data_in), 64'(exp_wd));
        check("bank_write_mask", 64'(bank_write_mask), 64'(exp_mask));
      end
      if (bus_ready) begin
        ready_cyc = cyc;
        last_err  = bus_error;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready at cycle %0d: got bus_ready=1 expected no completion", cyc);
        end else begin
          e = exp_q.pop_front();
          check("bus_error", 64'(bus_error), 64'(e[DW]));
          check("completion_data", 64'(data_out), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus_enable = 1'b0;
      bank_ready = 4'(($urandom_range(0, 15)) & ~32'(SLOW));
      exp_en = '0; exp_we = '0; exp_rdy = 1'b0;
    end
  endtask

  // nwait < 0: selected bank never ready (timeout path).
  task automatic txn(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [MW-1:0] m, input logic we, input int nwait,
                     output int start);
    int            b;
    int            n;
    logic [NB-1:0] sel;
    logic          err;
    logic [DW-1:0] nd;
    b   = int'(addr[AW-1 -: BB]);
    sel = NB'(1) << b;
    n   = SLOW[b] ? ((nwait < 0) ? TO : nwait) : 0;
    err = we && RO[b];
    nd  = model_data;
    if (SLOW[b] && nwait < 0) begin
      err = 1'b1;
      nd  = '1;
    end else if (!we) begin
      nd = bank_val[b];
    end
    // IDLE: request sampled
    @(posedge clk); #1;
    address = addr; data_in = wd; write_mask = m; write_enable = we; bus_enable = 1'b1;
    bank_ready = '0;
    exp_en = '0; exp_we = '0; exp_rdy = 1'b0;
    start = cyc;
    exp_q.push_back({err, nd});
    // ACCESS: scramble inputs, they must be ignored
    @(posedge clk); #1;
    bus_enable = 1'b0;
    address = AW'($urandom); data_in = $urandom; write_mask = MW'($urandom);
    write_enable = 1'($urandom);
    exp_en = sel; exp_we = (we && !RO[b]) ? sel : '0;
    exp_off = addr[AW-BB-1:0]; exp_wd = wd; exp_mask = m;
    if (SLOW[b]) bank_ready = (nwait == 0) ? sel : ~sel;
    else         bank_ready = NB'($urandom);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      bank_ready = ((i == nwait) ? sel : '0) | ((i % 2 == 1) ? ~sel : '0);
    end
    // DONE
    @(posedge clk); #1;
    bank_ready = '0;
    exp_en = '0; exp_we = '0; exp_rdy = 1'b1;
    model_data = nd;
    @(negedge clk); #1;
    check("latency", 64'(ready_cyc - start), 64'(2 + n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    reset = 1'b1; bus_enable = 1'b0; address = '0; data_in = '0;
    write_mask = '0; write_enable = 1'b0; bank_ready = '0;
    bank_val[0] = 32'h12345678; bank_val[1] = 32'h0BADF00D;
    bank_val[2] = 32'hCAFEF00D; bank_val[3] = 32'h55AA33CC;
    exp_en = '0; exp_we = '0; exp_rdy = 1'b0; model_data = '0;
    exp_off = '0; exp_wd = '0; exp_mask = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("reset_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;
    idle(2);

    // read fast bank 0
    txn(16'h0010, 32'h0, 4'h0, 1'b0, 0, s);
    check("pin_read0_data", 64'(data_out), 64'(32'h12345678));
    check("pin_read0_lat", 64'(ready_cyc - s), 64'(2));
    check("pin_read0_err", 64'(last_err), 64'(0));
    // write bank 3, data_out must hold
    txn(16'hC004, 32'hDEADBEEF, 4'b0011, 1'b1, 0, s);
    check("pin_write3_hold", 64'(data_out), 64'(32'h12345678));
    // write to RO bank 1
    txn(16'h4000, 32'h11112222, 4'b1111, 1'b1, 0, s);
    check("pin_ro_err", 64'(last_err), 64'(1));
    // slow read bank 2, ready after 5 WAIT cycles, other banks pulsed
    txn(16'h8020, 32'h0, 4'h0, 1'b0, 5, s);
    check("pin_slow_lat", 64'(ready_cyc - s), 64'(7));
    check("pin_slow_data", 64'(data_out), 64'(32'hCAFEF00D));
    // slow bank ready in ACCESS, write
    txn(16'h8FFC, 32'hA5A5A5A5, 4'b1000, 1'b1, 0, s);
    // read of RO bank is legal
    txn(16'h4ABC, 32'h0, 4'h0, 1'b0, 0, s);
    check("pin_ro_read_err", 64'(last_err), 64'(0));
    bank_val[3] = 32'h0F0F0F0F;
    idle(1);
    txn(16'hFFFC, 32'h0, 4'h0, 1'b0, 0, s);
    txn(16'h8004, 32'h0, 4'h0, 1'b0, 2, s);
`ifdef MEMORY_BUS_TIMEOUT_EN
    txn(16'h8008, 32'h0, 4'h0, 1'b0, -1, s);
    check("pin_timeout_data", 64'(data_out), 64'(32'hFFFFFFFF));
    check("pin_timeout_err", 64'(last_err), 64'(1));
`endif

    // reset during WAIT
    @(posedge clk); #1;
    address = 16'h8010; write_enable = 1'b0; bus_enable = 1'b1; bank_ready = '0;
    exp_en = '0; exp_we = '0; exp_rdy = 1'b0;
    @(posedge clk); #1;
    bus_enable = 1'b0;
    exp_en = 4'b0100; exp_we = '0; exp_off = 14'h0010; exp_wd = data_in; exp_mask = write_mask;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_en = '0; exp_rdy = 1'b0; model_data = '0;
    @(negedge clk); #1;
    check("pin_rst_bank_enable", 64'(bank_enable), 64'(0));
    check("pin_rst_bus_ready", 64'(bus_ready), 64'(0));
    check("pin_rst_state", 64'(dbg_state), 64'(0));
    check("pin_rst_data", 64'(data_out), 64'(0));
    txn(16'h0020, 32'h0, 4'h0, 1'b0, 0, s);
    check("pin_after_rst_data", 64'(data_out), 64'(32'h12345678));
    idle(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
